// File: rtl/alu_op_encoder_pkg.sv
// Shared definitions for the ALU op-select path: widths, named op codes and
// encoder FSM states.
package alu_op_encoder_pkg;

   localparam int unsigned N_OPS  = 8;
   localparam int unsigned CODE_W = $clog2(N_OPS);

   typedef logic [N_OPS-1:0]  op_vec_t;
   typedef logic [CODE_W-1:0] op_code_t;

   // Op codes shared with the one-hot op decoder
   localparam op_code_t OP_ADD = 3'd0;
   localparam op_code_t OP_SUB = 3'd1;
   localparam op_code_t OP_AND = 3'd2;
   localparam op_code_t OP_OR  = 3'd3;
   localparam op_code_t OP_XOR = 3'd4;
   localparam op_code_t OP_SLL = 3'd5;
   localparam op_code_t OP_SRL = 3'd6;
   localparam op_code_t OP_SRA = 3'd7;

   typedef enum logic {
      StIdle  = 1'b0,
      StIssue = 1'b1
   } state_e;

endpackage

// File: rtl/alu_op_encoder_if.sv
// Request-vector and op-code streams between the op-request logic, the encoder
// and the ALU select input.
interface alu_op_encoder_if;
   import alu_op_encoder_pkg::*;

   logic     req_valid;
   logic     req_ready;
   op_vec_t  req_vec;
   logic     op_valid;
   logic     op_ready;
   op_code_t op_code;
   logic     op_last;
   logic     err_empty;

   modport master (
      output req_valid, req_vec, op_ready,
      input  req_ready, op_valid, op_code, op_last, err_empty
   );

   modport slave (
      input  req_valid, req_vec, op_ready,
      output req_ready, op_valid, op_code, op_last, err_empty
   );

endinterface

// File: rtl/alu_op_encoder_lsb_prio_enc.sv
// Combinational lowest-set-bit priority encoder; also returns the input with
// that bit cleared so the caller can walk through all set bits.
module alu_op_encoder_lsb_prio_enc
   import alu_op_encoder_pkg::*;
(
   input  op_vec_t  in_i,
   output op_code_t idx_o,
   output logic     found_o,
   output op_vec_t  rest_o
);

   // Descending scan so the lowest set bit is the last one written
   always_comb begin
      idx_o = '0;
      for (int i = int'(N_OPS) - 1; i >= 0; i--) begin
         if (in_i[i]) begin
            idx_o = op_code_t'(i);
         end
      end
   end

   assign found_o = |in_i;
   assign rest_o  = in_i & (in_i - op_vec_t'(1));

endmodule

// File: rtl/alu_op_encoder.sv
// Sequential op encoder: accepts a request vector and issues the binary code of
// each set bit, lowest first, one per op-stream handshake.
module alu_op_encoder
   import alu_op_encoder_pkg::*;
(
   input logic             clk,
   input logic             rst,
   alu_op_encoder_if.slave bus_io
);

   state_e   state_q;
   op_vec_t  pending_q;
   logic     req_ready_q;
   logic     op_valid_q;
   op_code_t op_code_q;
   logic     op_last_q;
   logic     err_empty_q;

   op_vec_t  enc_in;
   op_code_t enc_idx;
   logic     enc_found;
   op_vec_t  enc_rest;

   // One shared encoder: fresh vector while idle, leftover bits while issuing
   assign enc_in = (state_q == StIdle) ? bus_io.req_vec : pending_q;

   alu_op_encoder_lsb_prio_enc u_prio_enc (
      .in_i    (enc_in),
      .idx_o   (enc_idx),
      .found_o (enc_found),
      .rest_o  (enc_rest)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         pending_q   <= '0;
         req_ready_q <= 1'b0;
         op_valid_q  <= 1'b0;
         op_code_q   <= '0;
         op_last_q   <= 1'b0;
         err_empty_q <= 1'b0;
      end else begin
         err_empty_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               req_ready_q <= 1'b1;
               if (bus_io.req_valid && req_ready_q) begin
                  if (!enc_found) begin
                     err_empty_q <= 1'b1;
                  end else begin
                     pending_q   <= enc_rest;
                     op_valid_q  <= 1'b1;
                     op_code_q   <= enc_idx;
                     op_last_q   <= (enc_rest == '0);
                     req_ready_q <= 1'b0;
                     state_q     <= StIssue;
                  end
               end
            end
            StIssue: begin
               if (op_valid_q && bus_io.op_ready) begin
                  if (op_last_q) begin
                     op_valid_q  <= 1'b0;
                     op_code_q   <= '0;
                     op_last_q   <= 1'b0;
                     req_ready_q <= 1'b1;
                     state_q     <= StIdle;
                  end else begin
                     op_code_q <= enc_idx;
                     op_last_q <= (enc_rest == '0);
                     pending_q <= enc_rest;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus_io.req_ready = req_ready_q;
   assign bus_io.op_valid  = op_valid_q;
   assign bus_io.op_code   = op_code_q;
   assign bus_io.op_last   = op_last_q;
   assign bus_io.err_empty = err_empty_q;

endmodule

// File: tb/tb_alu_op_encoder.sv
// Directed and randomized checks of alu_op_encoder against a set-bit queue model.
module tb_alu_op_encoder;
   import alu_op_encoder_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   alu_op_encoder_if enc_if ();

   alu_op_encoder dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (enc_if)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, observed running, required finished");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a vector for one handshake; an empty vector is checked here fully
   task automatic accept(input op_vec_t v);
      check("req_ready_pre_accept", enc_if.req_ready, 1);
      enc_if.req_valid = 1'b1;
      enc_if.req_vec   = v;
      tick();
      enc_if.req_valid = 1'b0;
      if (v == '0) begin
         check("err_empty_pulse", enc_if.err_empty, 1);
         check("op_valid_empty", enc_if.op_valid, 0);
         check("req_ready_empty", enc_if.req_ready, 1);
         tick();
         check("err_empty_clear", enc_if.err_empty, 0);
         check("op_valid_empty2", enc_if.op_valid, 0);
         check("req_ready_empty2", enc_if.req_ready, 1);
      end
   endtask

   // Expected codes = ascending indices of set bits; one handshake each
   task automatic issue(input op_vec_t v, input int max_stall, input int stall_code,
                        input int stall_len, input bit hold, input op_vec_t hold_vec);
      int exp_q[$];
      int code;
      int s;
      bit last;
      for (int i = 0; i < int'(N_OPS); i++) begin
         if (v[i]) exp_q.push_back(i);
      end
      while (exp_q.size() > 0) begin
         code = exp_q.pop_front();
         last = (exp_q.size() == 0);
         if (code == stall_code) s = stall_len;
         else if (max_stall > 0) s = int'($urandom_range(max_stall, 0));
         else s = 0;
         for (int c = 0; c <= s; c++) begin
            enc_if.op_ready  = (c == s);
            enc_if.req_valid = hold;
            enc_if.req_vec   = hold_vec;
            check("op_valid", enc_if.op_valid, 1);
            check("op_code", enc_if.op_code, code);
            check("op_last", enc_if.op_last, last);
            check("req_ready_issue", enc_if.req_ready, 0);
            check("err_empty_issue", enc_if.err_empty, 0);
            tick();
         end
         enc_if.op_ready = 1'b0;
      end
      check("op_valid_done", enc_if.op_valid, 0);
      check("op_last_done", enc_if.op_last, 0);
      check("req_ready_done", enc_if.req_ready, 1);
   endtask

   initial begin
      op_vec_t v;
      rst              = 1'b1;
      enc_if.req_valid = 1'b0;
      enc_if.req_vec   = '0;
      enc_if.op_ready  = 1'b0;
      #1;
      check("rst_req_ready", enc_if.req_ready, 0);
      check("rst_op_valid", enc_if.op_valid, 0);
      check("rst_op_code", enc_if.op_code, 0);
      check("rst_op_last", enc_if.op_last, 0);
      check("rst_err_empty", enc_if.err_empty, 0);
      tick();
      tick();
      rst = 1'b0;
      check("req_ready_before_edge", enc_if.req_ready, 0);
      tick();
      check("req_ready_after_release", enc_if.req_ready, 1);

      // Single request
      accept(8'b0010_0000);
      issue(8'b0010_0000, 0, -1, 0, 1'b0, '0);

      // Multi with 3 stall cycles on code 2
      accept(8'b1000_0101);
      issue(8'b1000_0101, 0, 2, 3, 1'b0, '0);

      // Empty vector
      accept(8'h00);

      // Full vector back to back, op_ready always high
      accept(8'hFF);
      issue(8'hFF, 0, -1, 0, 1'b0, '0);
      accept(8'hFF);
      issue(8'hFF, 0, -1, 0, 1'b0, '0);

      // Requests during ISSUE are ignored, then taken once idle
      accept(8'h0A);
      issue(8'h0A, 0, -1, 0, 1'b1, 8'h01);
      tick();
      issue(8'h01, 0, -1, 0, 1'b0, '0);

      // Reset mid-ISSUE with 8'b1100_0000 still pending
      accept(8'b1100_0001);
      check("pre_rst_op_code", enc_if.op_code, 0);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_op_valid", enc_if.op_valid, 0);
      check("mid_rst_req_ready", enc_if.req_ready, 0);
      check("mid_rst_op_last", enc_if.op_last, 0);
      tick();
      rst = 1'b0;
      enc_if.op_ready = 1'b1;
      check("post_rst_req_ready0", enc_if.req_ready, 0);
      tick();
      check("post_rst_req_ready1", enc_if.req_ready, 1);
      for (int k = 0; k < 4; k++) begin
         check("post_rst_no_codes", enc_if.op_valid, 0);
         tick();
      end
      enc_if.op_ready = 1'b0;

      // Random vectors with random backpressure
      for (int n = 0; n < 24; n++) begin
         v = op_vec_t'($urandom);
         if ($urandom_range(3, 0) == 0) v = '0;
         accept(v);
         if (v != '0) issue(v, 2, -1, 0, 1'b0, '0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
